// File: rtl/td4_pkg.sv
// Shared TD4 definitions: execution-controller state encodings and the ISA opcodes
// used by both the core and its execution controller.
package td4_pkg;

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_BRK  = 2'b11;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC_IM   = 4'b1110;
    localparam logic [3:0] OP_JMP_IM   = 4'b1111;

    function automatic logic is_halted(input logic [1:0] st);
        return (st == ST_HALT) || (st == ST_BRK);
    endfunction

endpackage

// File: rtl/td4_debounce.sv
// Button conditioner: 2-flop synchroniser, stability-count debounce and a 1-clk
// press pulse on the released->pressed edge of the debounced level (active-low button).
module td4_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Counter restarts whenever the synchronised input agrees with the debounced level.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d   = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 execution controller: run/halt/single-step/breakpoint FSM producing the
// one-cycle instruction-step enable for the core, plus an executed-instruction counter.
module td4_exec_ctrl
    import td4_pkg::*;
#(
    parameter int unsigned DIV_MAX    = 2500000,
    parameter int          DEB_CYCLES = 50000,
    parameter int          CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_btn_n,
    input  logic       step_btn_n,
    input  logic [3:0] pc,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    output logic       cpu_en,
    output logic       halted,
    output logic [1:0] state,
    output logic [7:0] step_count
);

    logic             run_press, step_press;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_en_q, cpu_en_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic             skip_q, skip_d;
    logic             counting, tick;

    td4_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (run_btn_n),
        .press_o (run_press)
    );

    td4_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (step_btn_n),
        .press_o (step_press)
    );

    assign counting = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign tick     = counting && (cnt_q == CNT_W'(DIV_MAX));

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        skip_d   = skip_q;
        case (state_q)
            ST_HALT: begin
                if (run_press) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b0;
                end else if (step_press) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    state_d = ST_HALT;
                end else if (tick) begin
                    // Skip flag lets the instruction at the breakpoint execute once after resume.
                    skip_d = 1'b0;
                    if (bp_en && (pc == bp_addr) && !skip_q) begin
                        state_d = ST_BRK;
                    end else begin
                        cpu_en_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (tick) begin
                    cpu_en_d = 1'b1;
                    state_d  = ST_HALT;
                end
            end
            ST_BRK: begin
                if (run_press) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (step_press) begin
                    state_d = ST_STEP;
                end
            end
        endcase
    end

    // Prescaler restarts on every state entry so each step period is measured from entry.
    always_comb begin
        if ((state_d != state_q) || !counting || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        step_cnt_d = step_cnt_q + {7'd0, cpu_en_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HALT;
            cnt_q      <= '0;
            cpu_en_q   <= 1'b0;
            step_cnt_q <= 8'd0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_en_q   <= cpu_en_d;
            step_cnt_q <= step_cnt_d;
            skip_q     <= skip_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = is_halted(state_q);
    assign state      = state_q;
    assign step_count = step_cnt_q;

endmodule
